imem_arbiter: RTL and testbench

//  Shares the single-port instruction memory between the core fetch unit and the program loader.
//  The loader is the debug/boot path that writes images and reads them back.

---
 rtl/imem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares a single-port, 1-cycle synchronous-read instruction
//               memory between the core fetch unit and the program loader.
//               Round-robin arbitration, loader lock mode and a fetch
//               response path with a one-entry hold register for
//               backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // fetch port
    input  logic                  i_f_req,
    input  logic [ADDR_WIDTH-1:0] i_f_addr,
    output logic                  o_f_gnt,
    output logic                  o_f_rvalid,
    output logic [DATA_WIDTH-1:0] o_f_rdata,
    input  logic                  i_f_rready,
    // loader port
    input  logic                  i_l_req,
    input  logic                  i_l_we,
    input  logic [ADDR_WIDTH-1:0] i_l_addr,
    input  logic [DATA_WIDTH-1:0] i_l_wdata,
    input  logic [DATA_BYTES-1:0] i_l_wen,
    input  logic                  i_l_lock,
    output logic                  o_l_gnt,
    output logic                  o_l_rvalid,
    output logic [DATA_WIDTH-1:0] o_l_rdata,
    // memory port
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    output logic [DATA_BYTES-1:0] o_m_wen,
    input  logic [DATA_WIDTH-1:0] i_m_rdata
);

    // Round-robin pointer holds the last winner; the other side wins a tie.
    localparam logic       c_RR_FETCH  = 1'b0;
    localparam logic       c_RR_LOADER = 1'b1;

    localparam logic [1:0] c_ST_EMPTY  = 2'd0;
    localparam logic [1:0] c_ST_BYPASS = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    logic                  r_rr_ptr;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [1:0]            r_f_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_l_rvalid;

    logic                  w_f_rvalid;
    logic                  w_fetch_ok;
    logic                  w_load_ok;
    logic                  w_f_gnt;
    logic                  w_l_gnt;

    // A fetch may only be accepted when its response slot will be free next
    // cycle. Both requests are masked while reset is asserted so that no
    // memory write can leak out during a mid-operation reset.
    assign w_f_rvalid = (r_f_state != c_ST_EMPTY);
    assign w_fetch_ok = rst_n & i_f_req & ~i_l_lock & (~w_f_rvalid | i_f_rready);
    assign w_load_ok  = rst_n & i_l_req;
    assign w_f_gnt    = w_fetch_ok & (~w_load_ok | (r_rr_ptr == c_RR_LOADER));
    assign w_l_gnt    = w_load_ok  & (~w_fetch_ok | (r_rr_ptr == c_RR_FETCH));

    assign o_f_gnt    = w_f_gnt;
    assign o_l_gnt    = w_l_gnt;
    assign o_f_rvalid = w_f_rvalid;
    assign o_l_rvalid = r_l_rvalid;
    assign o_l_rdata  = r_l_rvalid ? i_m_rdata : '0;

    // Memory drive: granted address, otherwise park on the last used address.
    always_comb begin
        o_m_addr  = r_last_addr;
        o_m_wen   = '0;
        o_m_wdata = i_l_wdata;
        if (w_f_gnt) begin
            o_m_addr = i_f_addr;
        end else if (w_l_gnt) begin
            o_m_addr = i_l_addr;
            if (i_l_we) begin
                o_m_wen = i_l_wen;
            end
        end
    end

    // Fetch read data comes straight from memory, or from the hold register
    // once the consumer has stalled.
    always_comb begin
        o_f_rdata = '0;
        if (r_f_state == c_ST_BYPASS) begin
            o_f_rdata = i_m_rdata;
        end else if (r_f_state == c_ST_HOLD) begin
            o_f_rdata = r_hold;
        end
    end

    // Arbitration history: winner pointer and parked address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= c_RR_LOADER;
            r_last_addr <= '0;
        end else begin
            if (w_f_gnt) begin
                r_rr_ptr    <= c_RR_FETCH;
                r_last_addr <= i_f_addr;
            end else if (w_l_gnt) begin
                r_rr_ptr    <= c_RR_LOADER;
                r_last_addr <= i_l_addr;
            end
        end
    end

    // Fetch response FSM with hold register for backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_state <= c_ST_EMPTY;
            r_hold    <= '0;
        end else begin
            case (r_f_state)
                c_ST_EMPTY: begin
                    if (w_f_gnt) begin
                        r_f_state <= c_ST_BYPASS;
                    end
                end
                c_ST_BYPASS: begin
                    if (i_f_rready) begin
                        r_f_state <= w_f_gnt ? c_ST_BYPASS : c_ST_EMPTY;
                    end else begin
                        r_hold    <= i_m_rdata;
                        r_f_state <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (i_f_rready) begin
                        r_f_state <= w_f_gnt ? c_ST_BYPASS : c_ST_EMPTY;
                    end
                end
                default: begin
                    r_f_state <= c_ST_EMPTY;
                end
            endcase
        end
    end

    // Loader reads return one cycle after grant; writes are silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l_rvalid <= 1'b0;
        end else begin
            r_l_rvalid <= w_l_gnt & ~i_l_we;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Scoreboard bench for imem_arbiter with a behavioural
//               single-port synchronous memory and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_f_req = 1'b0;
    logic [AW-1:0] i_f_addr = '0;
    logic          o_f_gnt;
    logic          o_f_rvalid;
    logic [DW-1:0] o_f_rdata;
    logic          i_f_rready = 1'b0;
    logic          i_l_req = 1'b0;
    logic          i_l_we = 1'b0;
    logic [AW-1:0] i_l_addr = '0;
    logic [DW-1:0] i_l_wdata = '0;
    logic [DB-1:0] i_l_wen = '0;
    logic          i_l_lock = 1'b0;
    logic          o_l_gnt;
    logic          o_l_rvalid;
    logic [DW-1:0] o_l_rdata;
    logic [AW-1:0] o_m_addr;
    logic [DW-1:0] o_m_wdata;
    logic [DB-1:0] o_m_wen;
    logic [DW-1:0] r_m_rdata = '0;

    logic [DW-1:0] r_mem     [0:2047];
    logic [DW-1:0] r_ref_mem [0:2047];
    logic [DW-1:0] f_q [$];
    logic [DW-1:0] l_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_f_req    (i_f_req),
        .i_f_addr   (i_f_addr),
        .o_f_gnt    (o_f_gnt),
        .o_f_rvalid (o_f_rvalid),
        .o_f_rdata  (o_f_rdata),
        .i_f_rready (i_f_rready),
        .i_l_req    (i_l_req),
        .i_l_we     (i_l_we),
        .i_l_addr   (i_l_addr),
        .i_l_wdata  (i_l_wdata),
        .i_l_wen    (i_l_wen),
        .i_l_lock   (i_l_lock),
        .o_l_gnt    (o_l_gnt),
        .o_l_rvalid (o_l_rvalid),
        .o_l_rdata  (o_l_rdata),
        .o_m_addr   (o_m_addr),
        .o_m_wdata  (o_m_wdata),
        .o_m_wen    (o_m_wen),
        .i_m_rdata  (r_m_rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {32'hC0DE_0000 | {21'd0, a}, 32'h0000_1000 + {21'd0, a}};
    endfunction

    // Behavioural memory: read-before-write, byte-enabled writes.
    always @(posedge clk) begin
        r_m_rdata <= r_mem[o_m_addr];
        for (int b = 0; b < DB; b++) begin
            if (o_m_wen[b]) r_mem[o_m_addr][8*b +: 8] <= o_m_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=unexpected-response required=none", nm);
    endtask

    // Scoreboard producer: on each grant, predict the response from the reference memory.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_f_gnt) f_q.push_back(r_ref_mem[i_f_addr]);
            if (o_l_gnt) begin
                if (i_l_we) begin
                    for (int b = 0; b < DB; b++)
                        if (i_l_wen[b]) r_ref_mem[i_l_addr][8*b +: 8] = i_l_wdata[8*b +: 8];
                end else begin
                    l_q.push_back(r_ref_mem[i_l_addr]);
                end
            end
        end
    end

    // Scoreboard consumer: compare whenever a response is presented and taken.
    always @(negedge clk) begin
        if (rst_n && o_f_rvalid && i_f_rready) begin
            if (f_q.size() == 0) fail_now("f_resp_extra");
            else chk("f_resp", o_f_rdata, f_q.pop_front());
        end
        if (rst_n && o_l_rvalid) begin
            if (l_q.size() == 0) fail_now("l_resp_extra");
            else chk("l_resp", o_l_rdata, l_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        f_q.delete();
        l_q.delete();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            r_mem[i]     = pat(i[AW-1:0]);
            r_ref_mem[i] = pat(i[AW-1:0]);
        end
        r_mem[5]     = '0;
        r_ref_mem[5] = '0;

        // Reset state
        #2;
        chk("rst_f_rvalid", {63'd0, o_f_rvalid}, 64'd0);
        chk("rst_l_rvalid", {63'd0, o_l_rvalid}, 64'd0);
        chk("rst_f_gnt",    {63'd0, o_f_gnt},    64'd0);
        chk("rst_m_addr",   {53'd0, o_m_addr},   64'd0);
        chk("rst_m_wen",    {56'd0, o_m_wen},    64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // T1: single fetch, latency 1
        i_f_req = 1'b1; i_f_addr = 11'h010; i_f_rready = 1'b1;
        neg();
        chk("t1_f_gnt",  {63'd0, o_f_gnt},  64'd1);
        chk("t1_l_gnt",  {63'd0, o_l_gnt},  64'd0);
        chk("t1_m_addr", {53'd0, o_m_addr}, 64'h010);
        cyc();
        i_f_req = 1'b0;
        neg();
        chk("t1_rvalid_n1", {63'd0, o_f_rvalid}, 64'd1);
        chk("t1_rdata",     o_f_rdata, pat(11'h010));
        cyc();
        neg();
        chk("t1_rvalid_n2", {63'd0, o_f_rvalid}, 64'd0);

        // T2: both requesting after reset -> F,L,F,L
        do_reset();
        i_f_req = 1'b1; i_f_addr = 11'h030;
        i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 11'h040;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("t2_f_gnt",    {63'd0, o_f_gnt},    (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("t2_l_gnt",    {63'd0, o_l_gnt},    (k % 2 == 1) ? 64'd1 : 64'd0);
            chk("t2_l_rvalid", {63'd0, o_l_rvalid}, (k == 2) ? 64'd1 : 64'd0);
            cyc();
            if (k == 3) begin
                i_f_req = 1'b0;
                i_l_req = 1'b0;
            end
        end
        neg();
        chk("t2_l_rvalid_tail", {63'd0, o_l_rvalid}, 64'd1);
        cyc();
        neg();
        chk("t2_l_rvalid_off", {63'd0, o_l_rvalid}, 64'd0);
        cyc();

        // T3: backpressure holds fetch data while memory address moves
        i_f_req = 1'b1; i_f_addr = 11'h020; i_f_rready = 1'b1;
        neg();
        chk("t3_f_gnt", {63'd0, o_f_gnt}, 64'd1);
        cyc();
        for (int j = 0; j < 3; j++) begin
            i_f_addr = 11'h021; i_f_rready = 1'b0;
            i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 11'h100 + 11'(j);
            neg();
            chk("t3_hold_no_fgnt", {63'd0, o_f_gnt},    64'd0);
            chk("t3_hold_lgnt",    {63'd0, o_l_gnt},    64'd1);
            chk("t3_hold_rvalid",  {63'd0, o_f_rvalid}, 64'd1);
            chk("t3_hold_rdata",   o_f_rdata, pat(11'h020));
            cyc();
        end
        i_f_rready = 1'b1; i_l_req = 1'b0;
        neg();
        chk("t3_release_gnt", {63'd0, o_f_gnt}, 64'd1);
        chk("t3_release_rdata", o_f_rdata, pat(11'h020));
        cyc();
        i_f_req = 1'b0;
        neg();
        chk("t3_next_rdata", o_f_rdata, pat(11'h021));
        cyc();
        neg();
        chk("t3_idle_rvalid", {63'd0, o_f_rvalid}, 64'd0);
        cyc();

        // T4: lock blocks fetch during image write
        i_l_lock = 1'b1;
        i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 11'h7FF;
        i_l_wdata = 64'h0000_0000_0AB0_CDEF; i_l_wen = 8'hFF;
        i_f_req = 1'b1; i_f_addr = 11'h7FF;
        neg();
        chk("t4_l_gnt",  {63'd0, o_l_gnt},  64'd1);
        chk("t4_f_gnt",  {63'd0, o_f_gnt},  64'd0);
        chk("t4_m_wen",  {56'd0, o_m_wen},  64'hFF);
        chk("t4_m_addr", {53'd0, o_m_addr}, 64'h7FF);
        cyc();
        i_l_req = 1'b0; i_l_we = 1'b0; i_l_wen = 8'h00;
        neg();
        chk("t4_locked_f_gnt", {63'd0, o_f_gnt}, 64'd0);
        cyc();
        i_l_lock = 1'b0;
        neg();
        chk("t4_unlock_f_gnt", {63'd0, o_f_gnt}, 64'd1);
        cyc();
        i_f_req = 1'b0;
        neg();
        chk("t4_rdata", o_f_rdata, 64'h0000_0000_0AB0_CDEF);
        cyc();

        // T5: partial byte-enable write then readback
        i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 11'h005;
        i_l_wdata = '1; i_l_wen = 8'h0F;
        neg();
        chk("t5_wr_gnt", {63'd0, o_l_gnt}, 64'd1);
        chk("t5_m_wen",  {56'd0, o_m_wen}, 64'h0F);
        cyc();
        i_l_we = 1'b0; i_l_wen = 8'h00;
        neg();
        chk("t5_rd_gnt",   {63'd0, o_l_gnt}, 64'd1);
        chk("t5_rd_m_wen", {56'd0, o_m_wen}, 64'd0);
        cyc();
        i_l_req = 1'b0;
        neg();
        chk("t5_l_rvalid", {63'd0, o_l_rvalid}, 64'd1);
        chk("t5_l_rdata",  o_l_rdata, 64'h0000_0000_FFFF_FFFF);
        cyc();

        // T7: loader write to the address whose fetch is being held
        i_f_req = 1'b1; i_f_addr = 11'h030; i_f_rready = 1'b1;
        neg();
        chk("t7_f_gnt", {63'd0, o_f_gnt}, 64'd1);
        cyc();
        i_f_req = 1'b0; i_f_rready = 1'b0;
        i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 11'h030;
        i_l_wdata = 64'hDEAD_BEEF_0000_0000; i_l_wen = 8'hFF;
        neg();
        chk("t7_l_gnt", {63'd0, o_l_gnt}, 64'd1);
        cyc();
        i_l_req = 1'b0; i_l_we = 1'b0; i_l_wen = 8'h00;
        neg();
        chk("t7_hold_pre_write", o_f_rdata, pat(11'h030));
        cyc();
        i_f_rready = 1'b1;
        neg();
        chk("t7_release_pre_write", o_f_rdata, pat(11'h030));
        cyc();
        i_l_req = 1'b1; i_l_addr = 11'h030;
        neg();
        cyc();
        i_l_req = 1'b0;
        neg();
        chk("t7_readback", o_l_rdata, 64'hDEAD_BEEF_0000_0000);
        cyc();

        // T6: asynchronous reset during HOLD
        i_f_req = 1'b1; i_f_addr = 11'h040; i_f_rready = 1'b1;
        neg();
        chk("t6_f_gnt", {63'd0, o_f_gnt}, 64'd1);
        cyc();
        i_f_req = 1'b0; i_f_rready = 1'b0;
        cyc();
        neg();
        chk("t6_hold_rvalid", {63'd0, o_f_rvalid}, 64'd1);
        #1;
        i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 11'h040;
        i_l_wdata = 64'h1111_2222_3333_4444; i_l_wen = 8'hFF;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rvalid", {63'd0, o_f_rvalid}, 64'd0);
        chk("t6_rst_m_wen",    {56'd0, o_m_wen},    64'd0);
        chk("t6_rst_l_gnt",    {63'd0, o_l_gnt},    64'd0);
        f_q.delete();
        l_q.delete();
        cyc();
        i_l_req = 1'b0; i_l_we = 1'b0; i_l_wen = 8'h00;
        cyc();
        rst_n = 1'b1;
        i_f_rready = 1'b1;
        i_f_req = 1'b1; i_f_addr = 11'h050;
        i_l_req = 1'b1; i_l_addr = 11'h040;
        neg();
        chk("t6_tie_f_gnt", {63'd0, o_f_gnt}, 64'd1);
        chk("t6_tie_l_gnt", {63'd0, o_l_gnt}, 64'd0);
        cyc();
        i_f_req = 1'b0;
        neg();
        chk("t6_l_gnt_next", {63'd0, o_l_gnt}, 64'd1);
        cyc();
        i_l_req = 1'b0;
        neg();
        chk("t6_no_write_leak", o_l_rdata, pat(11'h040));
        cyc();
        neg();
        chk("f_q_drained", 64'(f_q.size()), 64'd0);
        chk("l_q_drained", 64'(l_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
